// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame controller: frame marker,
// error codes and the frame FSM state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Assembles UART bytes into SYNC/OP/LEN/payload/CHK frames, validates them and
// presents good frames on a valid/ready interface; errors pulse frame_err_o.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     rx_byte_i,
    input  logic                           rx_ready_i,
    output logic                           cmd_valid_o,
    input  logic                           cmd_ready_i,
    output logic [7:0]                     cmd_op_o,
    output logic [$clog2(MAX_LEN+1)-1:0]   cmd_len_o,
    output logic [MAX_LEN*8-1:0]           cmd_payload_o,
    output logic                           frame_err_o,
    output logic [1:0]                     err_code_o,
    output logic                           busy_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    // Counter is compared one short so the abort lands on the TIMEOUT_CYC-th idle edge.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e               state_q;
    logic                 cmd_valid_q;
    logic [7:0]           cmd_op_q;
    logic [LEN_W-1:0]     cmd_len_q;
    logic [MAX_LEN*8-1:0] cmd_payload_q;
    logic                 frame_err_q;
    logic [1:0]           err_code_q;
    logic [7:0]           acc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TO_W-1:0]      to_cnt_q;

    logic in_frame;
    assign in_frame = (state_q == ST_OP) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    // NOTE: every state register uses <= so all branches see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_op_q      <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_CHECKSUM;
            acc_q         <= '0;
            idx_q         <= '0;
            to_cnt_q      <= '0;
        end else begin
            frame_err_q <= 1'b0;

            if (in_frame) begin
                if (rx_ready_i) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                    state_q     <= ST_IDLE;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (rx_ready_i && rx_byte_i == SYNC_BYTE) begin
                        state_q       <= ST_OP;
                        cmd_payload_q <= '0;
                        acc_q         <= '0;
                        idx_q         <= '0;
                        to_cnt_q      <= '0;
                    end
                end
                ST_OP: begin
                    if (rx_ready_i) begin
                        cmd_op_q <= rx_byte_i;
                        acc_q    <= rx_byte_i;
                        state_q  <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_ready_i) begin
                        if (rx_byte_i > 8'(MAX_LEN)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LENGTH;
                            state_q     <= ST_IDLE;
                        end else begin
                            cmd_len_q <= LEN_W'(rx_byte_i);
                            acc_q     <= acc_q ^ rx_byte_i;
                            state_q   <= (rx_byte_i == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_ready_i) begin
                        cmd_payload_q[8*idx_q +: 8] <= rx_byte_i;
                        acc_q <= acc_q ^ rx_byte_i;
                        idx_q <= idx_q + 1'b1;
                        if (LEN_W'(idx_q) == cmd_len_q - LEN_W'(1)) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (rx_ready_i) begin
                        if (rx_byte_i == acc_q) begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHECKSUM;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cmd_valid_q && cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                    // A byte here has nowhere to go; the held frame wins.
                    if (rx_ready_i) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= ERR_OVERRUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_op_o      = cmd_op_q;
    assign cmd_len_o     = cmd_len_q;
    assign cmd_payload_o = cmd_payload_q;
    assign frame_err_o   = frame_err_q;
    assign err_code_o    = err_code_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: good frames, length/checksum/timeout/overrun
// errors and mid-frame reset, with hand-computed expected values.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    uart_cmd_ctrl #(.MAX_LEN(8), .TIMEOUT_CYC(1024), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte_i     (rx_byte),
        .rx_ready_i    (rx_ready),
        .cmd_valid_o   (cmd_valid),
        .cmd_ready_i   (cmd_ready),
        .cmd_op_o      (cmd_op),
        .cmd_len_o     (cmd_len),
        .cmd_payload_o (cmd_payload),
        .frame_err_o   (frame_err),
        .err_code_o    (err_code),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; strobes one byte across the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
    endtask

    int n;

    initial begin
        rst_n     = 1'b0;
        rx_byte   = 8'h00;
        rx_ready  = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid",   cmd_valid,   0);
        check("rst_op",      cmd_op,      0);
        check("rst_len",     cmd_len,     0);
        check("rst_payload", cmd_payload, 0);
        check("rst_err",     frame_err,   0);
        check("rst_code",    err_code,    0);
        check("rst_busy",    busy,        0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame, downstream always ready
        cmd_ready = 1'b1;
        send_byte(8'hA5);
        check("a_busy", busy, 1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        check("a_no_valid_early", cmd_valid, 0);
        send_byte(8'h30);
        check("a_valid",   cmd_valid,   1);
        check("a_op",      cmd_op,      8'h01);
        check("a_len",     cmd_len,     2);
        check("a_payload", cmd_payload, 64'h2211);
        check("a_err",     frame_err,   0);
        @(negedge clk);
        check("a_valid_drop", cmd_valid, 0);
        check("a_idle",       busy,      0);

        // Length too large, then a good frame
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
        check("len_err",  frame_err, 1);
        check("len_code", err_code,  1);
        check("len_busy", busy,      0);
        @(negedge clk);
        check("len_pulse_one", frame_err, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h30);
        check("len_next_valid",   cmd_valid,   1);
        check("len_next_payload", cmd_payload, 64'h2211);
        @(negedge clk);

        // Zero length, good then bad checksum
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
        check("z_valid",   cmd_valid,   1);
        check("z_op",      cmd_op,      8'h07);
        check("z_len",     cmd_len,     0);
        check("z_payload", cmd_payload, 0);
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h08);
        check("ck_err",   frame_err, 1);
        check("ck_code",  err_code,  0);
        check("ck_valid", cmd_valid, 0);
        check("ck_busy",  busy,      0);
        @(negedge clk);

        // Leading junk ignored, then a stalled frame times out
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_err",  frame_err, 0);
        check("junk_busy", busy,      0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
        n = 0;
        while (!frame_err && n <= 1100) begin
            @(negedge clk);
            n++;
        end
        check("to_seen",  frame_err, 1);
        check("to_cycles", n, 1024);
        check("to_code",  err_code,  2);
        check("to_busy",  busy,      0);
        check("to_valid", cmd_valid, 0);
        @(negedge clk);

        // Overrun while holding a frame
        cmd_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h57);
        check("ov_valid", cmd_valid, 1);
        repeat (2) @(negedge clk);
        check("ov_hold", cmd_valid, 1);
        send_byte(8'h55);
        check("ov_err",     frame_err,   1);
        check("ov_code",    err_code,    3);
        check("ov_valid2",  cmd_valid,   1);
        check("ov_op",      cmd_op,      8'h03);
        check("ov_len",     cmd_len,     1);
        check("ov_payload", cmd_payload, 64'h55);
        check("ov_busy",    busy,        1);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("ov_hs_valid", cmd_valid, 0);
        check("ov_hs_busy",  busy,      0);

        // Reset mid-payload, then a fresh good frame
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB);
        check("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mr_valid",   cmd_valid,   0);
        check("mr_op",      cmd_op,      0);
        check("mr_len",     cmd_len,     0);
        check("mr_payload", cmd_payload, 0);
        check("mr_code",    err_code,    0);
        check("mr_err",     frame_err,   0);
        check("mr_busy",    busy,        0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        send_byte(8'hC3); send_byte(8'hC6);
        check("mr_next_valid",   cmd_valid,   1);
        check("mr_next_op",      cmd_op,      8'h04);
        check("mr_next_len",     cmd_len,     1);
        check("mr_next_payload", cmd_payload, 64'hC3);
        @(negedge clk);
        check("mr_next_done", cmd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Frame-level controller that sequences the UART byte receiver output (rx_byte/rx_ready) into validated command frames. Frame format: SYNC (0xA5), OP, LEN, LEN payload bytes, CHK, where CHK is the XOR of OP, LEN and all payload bytes. A completed frame is presented on a valid/ready command interface to the downstream register/command logic. Length, checksum, inter-byte-timeout and overrun errors are reported as single-cycle pulses with a code.

Parameters:
MAX_LEN, 8, maximum payload bytes per frame (1..32)
TIMEOUT_CYC, 1024, idle clk cycles between bytes before a partial frame is aborted
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  byte from UART byte receiver, valid only when rx_ready=1
rx_ready  input  1  single-cycle strobe, one per received byte
cmd_valid  output  1  complete, checksum-good frame available
cmd_ready  input  1  downstream accepts frame
cmd_op  output  8  frame opcode
cmd_len  output  $clog2(MAX_LEN+1)  payload byte count
cmd_payload  output  MAX_LEN*8  payload; byte i at [8i+7:8i]; unused bytes zero
frame_err  output  1  single-cycle error pulse
err_code  output  2  0=CHECKSUM 1=LENGTH 2=TIMEOUT 3=OVERRUN; holds last value
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_valid=0, cmd_op=0, cmd_len=0, cmd_payload=0, frame_err=0, err_code=0, busy=0, checksum accumulator=0, timeout counter=0.
- States: IDLE, OP, LEN, PAYLOAD, CHECK, HOLD.
- IDLE: rx_ready with rx_byte==SYNC_BYTE -> OP; clear cmd_payload, accumulator, byte index. Other bytes are silently discarded.
- OP: on rx_ready, latch cmd_op, acc=byte -> LEN.
- LEN: on rx_ready, if byte>MAX_LEN -> pulse frame_err, err_code=LENGTH, go IDLE. Else latch cmd_len, acc^=byte; byte==0 -> CHECK, else -> PAYLOAD.
- PAYLOAD: each rx_ready writes byte at index, acc^=byte, index++; after byte cmd_len-1 -> CHECK.
- CHECK: on rx_ready, byte==acc -> HOLD with cmd_valid=1 the next cycle (1 cycle after CHK strobe). Mismatch -> frame_err, err_code=CHECKSUM, go IDLE.
- HOLD: cmd_valid held and all cmd_* outputs stable until cmd_ready=1. On cmd_valid&cmd_ready, next cycle cmd_valid=0, state IDLE. cmd_ready while cmd_valid=0 is ignored.
- An rx_ready arriving in HOLD, including the handshake cycle, drops the byte and pulses frame_err with err_code=OVERRUN. State and cmd outputs are unaffected.
- Timeout: counter runs in OP/LEN/PAYLOAD/CHECK, clears on every rx_ready and on entering OP. On reaching TIMEOUT_CYC: frame_err, err_code=TIMEOUT, go IDLE. Partial outputs are not presented. No timeout in IDLE or HOLD.
- A SYNC_BYTE value inside a frame is ordinary data. There is no resync mid-frame.
- frame_err is exactly one cycle per error event. err_code is updated in the same cycle.
- Reset asserted mid-frame or in HOLD: immediate return to reset values, and the frame is lost.
- Widths: accumulator 8 bits XOR; index $clog2(MAX_LEN) bits; timeout counter $clog2(TIMEOUT_CYC+1) bits, saturating at compare.

Decomposition:
- Package uart_cmd_pkg: SYNC_BYTE default, err code constants (ERR_CHECKSUM/LENGTH/TIMEOUT/OVERRUN), state enum typedef.
- No sub-module needed. The uart_rx_byte instance lives in the parent, which connects rx_byte/rx_ready directly.

Test Plan:
- Good frame A5 01 02 11 22 30, cmd_ready=1 -> cmd_valid 1 cycle after CHK strobe, cmd_op=01, cmd_len=2, cmd_payload[15:0]=16'h2211, upper bytes 0; IDLE next cycle.
- Zero-length A5 07 00 07 -> cmd_valid, cmd_len=0, payload all zero. Same frame with CHK 08 -> frame_err, err_code=0, no cmd_valid.
- A5 01 09 (MAX_LEN=8) -> frame_err, err_code=1 on LEN strobe. A following good frame is accepted normally.
- A5 01 02 11, then no bytes for 1024 cycles -> frame_err, err_code=2, busy falls. Leading bytes 00 FF before A5 are ignored with no error.
- Good frame with cmd_ready=0; send byte 55 during HOLD -> frame_err, err_code=3, cmd outputs unchanged; raise cmd_ready -> handshake completes.
- rst_n low for 1 cycle mid-PAYLOAD -> all outputs at reset values immediately; a subsequent good frame is decoded correctly.
